memcore_fifo: RTL and testbench

//  Synchronous single-clock FIFO memory core that is the design-under-check directly downstream of the aqed

---
 rtl/memcore_fifo_pkg.sv | 13 +
 rtl/memcore_fifo_ram.sv | 32 +++
 rtl/memcore_fifo.sv | 114 +++++++++++
 tb/tb_memcore_fifo.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/memcore_fifo_pkg.sv
// memcore_fifo shared sizing constants and types.
// Used by memcore_fifo and memcore_fifo_ram.
package memcore_fifo_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 128;
    localparam int ADDR_WIDTH = 7;

    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef logic [ADDR_WIDTH:0]   cnt_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/memcore_fifo_ram.sv
// DEPTH x DATA_WIDTH 1R1W storage, registered read.
// A same-address read and write returns the old word.
module memcore_fifo_ram
    import memcore_fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/memcore_fifo.sv
// Single-clock FIFO core with 1-cycle read latency and empty bypass.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow_err/underflow_err.
module memcore_fifo
    import memcore_fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  wen_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  ren_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   num_words
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow_err,
    output logic                  underflow_err
`endif
);

    ptr_t  rd_ptr;
    ptr_t  wr_ptr;
    cnt_t  count;
    logic  valid_q;
    logic  sel_byp;
    word_t byp_q;
    word_t ram_q;

    logic wr_acc;
    logic rd_acc;
    logic bypass;
    logic upd;
    logic ram_we;
    logic ram_re;

    assign empty  = (count == '0);
    assign full   = (count == cnt_t'(DEPTH));
    assign wr_acc = wen_in & (~full | ren_in);
    assign rd_acc = ren_in & (~empty | wen_in);
    assign bypass = empty & wen_in & ren_in;
    assign upd    = clk_en & ~reset & ~flush;
    assign ram_we = upd & wr_acc;
    assign ram_re = upd & rd_acc & ~empty;

    memcore_fifo_ram u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // The output word comes from either the RAM read register or the
    // bypass register; both only change on an accepted read.
    assign data_out  = sel_byp ? byp_q : ram_q;
    assign valid_out = valid_q;
    assign num_words = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            sel_byp <= 1'b0;
            byp_q   <= '0;
        end else if (clk_en) begin
            if (flush) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                valid_q <= 1'b0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
                if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
                if (wr_acc & ~rd_acc) begin
                    count <= count + 1'b1;
                end else if (rd_acc & ~wr_acc) begin
                    count <= count - 1'b1;
                end
                valid_q <= rd_acc;
                if (rd_acc) begin
                    sel_byp <= bypass;
                    if (bypass) byp_q <= data_in;
                end
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                overflow_err  <= 1'b0;
                underflow_err <= 1'b0;
            end else begin
                if (wen_in & full & ~ren_in)   overflow_err  <= 1'b1;
                if (ren_in & empty & ~wen_in)  underflow_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memcore_fifo.sv
// Directed self-checking bench for memcore_fifo.
// Error-flag steps run only when FIFO_ERR_FLAGS_EN is defined.
module tb_memcore_fifo;
    import memcore_fifo_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        flush;
    logic        wen_in;
    logic [15:0] data_in;
    logic        ren_in;
    logic [15:0] data_out;
    logic        valid_out;
    logic        empty;
    logic        full;
    logic [7:0]  num_words;
`ifdef FIFO_ERR_FLAGS_EN
    logic        overflow_err;
    logic        underflow_err;
`endif

    int errors = 0;
    int checks = 0;

    memcore_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .flush     (flush),
        .wen_in    (wen_in),
        .data_in   (data_in),
        .ren_in    (ren_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .empty     (empty),
        .full      (full),
        .num_words (num_words)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b1; flush = 1'b0;
        wen_in = 1'b0; ren_in = 1'b0; data_in = '0;
        step();
        step();
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_valid", 32'(valid_out), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_num", 32'(num_words), 0);
        reset = 1'b0;

        // 1: three writes then three reads
        wen_in = 1'b1; data_in = 16'h0011; step();
        data_in = 16'h0022; step();
        data_in = 16'h0033; step();
        check("t1_num3", 32'(num_words), 3);
        check("t1_nvalid", 32'(valid_out), 0);
        wen_in = 1'b0; ren_in = 1'b1; step();
        check("t1_v0", 32'(valid_out), 1);
        check("t1_d0", 32'(data_out), 32'h0011);
        step();
        check("t1_v1", 32'(valid_out), 1);
        check("t1_d1", 32'(data_out), 32'h0022);
        step();
        check("t1_v2", 32'(valid_out), 1);
        check("t1_d2", 32'(data_out), 32'h0033);
        check("t1_empty", 32'(empty), 1);
        ren_in = 1'b0; step();
        check("t1_vend", 32'(valid_out), 0);
        check("t1_hold", 32'(data_out), 32'h0033);

        // 2: empty bypass
        wen_in = 1'b1; ren_in = 1'b1; data_in = 16'hBEEF; step();
        check("t2_data", 32'(data_out), 32'hBEEF);
        check("t2_valid", 32'(valid_out), 1);
        check("t2_num", 32'(num_words), 0);
        check("t2_empty", 32'(empty), 1);
        wen_in = 1'b0; ren_in = 1'b1; step();
        check("t2_uflow_v", 32'(valid_out), 0);
        check("t2_uflow_n", 32'(num_words), 0);
        ren_in = 1'b0;

        // 3: fill, drop on full, simultaneous wen+ren on full
        wen_in = 1'b1;
        for (int i = 0; i < 128; i++) begin
            data_in = 16'(i);
            step();
        end
        check("t3_full", 32'(full), 1);
        check("t3_num", 32'(num_words), 128);
        data_in = 16'hAAAA; step();
        check("t3_drop_n", 32'(num_words), 128);
        check("t3_drop_f", 32'(full), 1);
        data_in = 16'h5555; ren_in = 1'b1; step();
        check("t3_head", 32'(data_out), 0);
        check("t3_hvalid", 32'(valid_out), 1);
        check("t3_num2", 32'(num_words), 128);
        wen_in = 1'b0;
        for (int i = 1; i <= 128; i++) begin
            step();
            check("t3_drain", 32'(data_out),
                  (i == 128) ? 32'h5555 : 32'(i));
        end
        check("t3_empty", 32'(empty), 1);
        ren_in = 1'b0;

        // 4: flush
        wen_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = 16'(16'h0100 + i);
            step();
        end
        check("t4_num5", 32'(num_words), 5);
        wen_in = 1'b0; flush = 1'b1; step();
        flush = 1'b0;
        check("t4_num", 32'(num_words), 0);
        check("t4_empty", 32'(empty), 1);
        check("t4_valid", 32'(valid_out), 0);
        check("t4_dhold", 32'(data_out), 32'h5555);
        wen_in = 1'b1; data_in = 16'h0007; step();
        wen_in = 1'b0; ren_in = 1'b1; step();
        check("t4_data", 32'(data_out), 32'h0007);
        check("t4_v", 32'(valid_out), 1);
        ren_in = 1'b0;

        // 5: clk_en low holds everything
        wen_in = 1'b1; data_in = 16'h0A01; step();
        data_in = 16'h0A02; step();
        check("t5_num2", 32'(num_words), 2);
        clk_en = 1'b0; ren_in = 1'b1; data_in = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_num", 32'(num_words), 2);
            check("t5_data", 32'(data_out), 32'h0007);
            check("t5_valid", 32'(valid_out), 0);
        end
        clk_en = 1'b1; wen_in = 1'b0; step();
        check("t5_rd", 32'(data_out), 32'h0A01);
        check("t5_rdv", 32'(valid_out), 1);
        check("t5_num1", 32'(num_words), 1);
        ren_in = 1'b0;
        reset = 1'b1; step();
        reset = 1'b0;
        check("t5_rst_num", 32'(num_words), 0);
        check("t5_rst_d", 32'(data_out), 0);

`ifdef FIFO_ERR_FLAGS_EN
        // 6: sticky error flags
        check("t6_u0", 32'(underflow_err), 0);
        ren_in = 1'b1; step();
        ren_in = 1'b0;
        check("t6_u1", 32'(underflow_err), 1);
        step();
        check("t6_usticky", 32'(underflow_err), 1);
        flush = 1'b1; step();
        flush = 1'b0;
        check("t6_uflush", 32'(underflow_err), 0);
        wen_in = 1'b1;
        for (int i = 0; i < 128; i++) begin
            data_in = 16'(i);
            step();
        end
        check("t6_o0", 32'(overflow_err), 0);
        step();
        wen_in = 1'b0;
        check("t6_o1", 32'(overflow_err), 1);
        step();
        check("t6_osticky", 32'(overflow_err), 1);
        reset = 1'b1; step();
        reset = 1'b0;
        check("t6_orst", 32'(overflow_err), 0);
        check("t6_urst", 32'(underflow_err), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
